imm_table_sequencer: RTL and testbench

- Sequences and shares the single 3-bit-select / 16-bit-output immediate table between two requesters: requester 0 is decode (ALU immediates), requester 1 is the branch unit (offsets).
- Supports plain lookups and chained lookups. A chain accumulates the sum of several table entries, so constants outside the table can be built from multiple 10-bit instructions.
- Sits between the decode/branch stages and the immediate table.
- The 16-bit result goes to the operand mux.

---
 rtl/imm_table_sequencer_if.sv | 37 +++
 rtl/imm_table_sequencer.sv | 174 +++++++++++++++++
 tb/tb_imm_table_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_table_sequencer_if.sv
// imm_table_sequencer_if
// Bundles the two requester handshakes, the immediate-table port and the
// result port of imm_table_sequencer.
//   master : requesters + table side (drives req/sel/ext and imm_in)
//   slave  : the sequencer (drives gnt, imm_sel and the result signals)
// Signals:
//   req0/sel0/ext0/gnt0  requester 0 (decode) beat handshake
//   req1/sel1/ext1/gnt1  requester 1 (branch unit) beat handshake
//   imm_sel/imm_in       table select (registered) and table data
//   q/q_valid/q_id/q_ovf/q_err  accumulated result and status
interface imm_table_sequencer_if;
    logic        req0;
    logic [2:0]  sel0;
    logic        ext0;
    logic        gnt0;
    logic        req1;
    logic [2:0]  sel1;
    logic        ext1;
    logic        gnt1;
    logic [2:0]  imm_sel;
    logic [15:0] imm_in;
    logic [15:0] q;
    logic        q_valid;
    logic        q_id;
    logic        q_ovf;
    logic        q_err;

    modport master (
        output req0, sel0, ext0, req1, sel1, ext1, imm_in,
        input  gnt0, gnt1, imm_sel, q, q_valid, q_id, q_ovf, q_err
    );

    modport slave (
        input  req0, sel0, ext0, req1, sel1, ext1, imm_in,
        output gnt0, gnt1, imm_sel, q, q_valid, q_id, q_ovf, q_err
    );
endinterface

// File: rtl/imm_table_sequencer.sv
// imm_table_sequencer
// Shares the 8-entry x 16-bit immediate table between decode (requester 0)
// and the branch unit (requester 1). A transaction is one or more table
// beats; chained beats are summed modulo 2^16 so constants outside the
// table can be built up. Ties between requesters are broken round-robin.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    imm_table_sequencer_if.slave (handshakes, table port, result)
// Parameters:
//   MAX_BEATS   maximum beats per chain (1..8); a longer chain is truncated
//   TMO_CYCLES  idle-wait limit in CHAIN (timeout build only)
// Build option:
//   IMM_CHAIN_TIMEOUT_EN  when defined, a chain whose owner stops sending
//                         beats is closed after TMO_CYCLES with q_err=1;
//                         otherwise CHAIN waits forever and q_err is 0.
//
// state | meaning
// IDLE  | arbitrate and accept the first beat of a transaction
// LOOK  | table data for imm_sel is valid; add it into the accumulator
// CHAIN | wait for the owner's next beat (other requester locked out)
// DONE  | result strobe cycle; no grants
module imm_table_sequencer #(
    parameter int MAX_BEATS  = 4,
    parameter int TMO_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imm_table_sequencer_if.slave  bus
);

    if (MAX_BEATS < 1 || MAX_BEATS > 8 || TMO_CYCLES < 1) begin : g_bad_param
        $error("imm_table_sequencer: MAX_BEATS must be 1..8 and TMO_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, LOOK, CHAIN, DONE} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BEATS);

    state_t      state;
    logic [15:0] acc;
    logic [3:0]  count;
    logic        owner;
    logic        rr_last;
    logic        ext_q;
    logic [2:0]  imm_sel_r;
    logic [15:0] q_r;
    logic        q_valid_r;
    logic        q_id_r;
    logic        q_ovf_r;

    logic        any_req;
    logic        win;
    logic        src;
    logic        owner_req;
    logic [2:0]  beat_sel;
    logic        beat_ext;
    logic [15:0] acc_next;

    assign any_req   = bus.req0 | bus.req1;
    // Single requester wins outright; on a tie the one not granted last wins.
    assign win       = (bus.req0 & bus.req1) ? ~rr_last : bus.req1;
    assign src       = (state == IDLE) ? win : owner;
    assign owner_req = owner ? bus.req1 : bus.req0;
    assign beat_sel  = src ? bus.sel1 : bus.sel0;
    assign beat_ext  = src ? bus.ext1 : bus.ext0;
    assign acc_next  = acc + bus.imm_in;

    // Grants are gated by reset so nothing is accepted while held in reset.
    assign bus.gnt0 = rst_n & (((state == IDLE) & any_req & ~win) |
                               ((state == CHAIN) & ~owner & bus.req0));
    assign bus.gnt1 = rst_n & (((state == IDLE) & any_req & win) |
                               ((state == CHAIN) & owner & bus.req1));

    assign bus.imm_sel = imm_sel_r;
    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
    assign bus.q_id    = q_id_r;
    assign bus.q_ovf   = q_ovf_r;

`ifdef IMM_CHAIN_TIMEOUT_EN
    localparam int WAIT_W = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TMO_CYCLES);

    logic [WAIT_W-1:0] wait_cnt;
    logic              q_err_r;

    assign bus.q_err = q_err_r;
`else
    assign bus.q_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            ext_q     <= 1'b0;
            imm_sel_r <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            q_id_r    <= 1'b0;
            q_ovf_r   <= 1'b0;
`ifdef IMM_CHAIN_TIMEOUT_EN
            wait_cnt  <= '0;
            q_err_r   <= 1'b0;
`endif
        end else begin
            q_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        imm_sel_r <= beat_sel;
                        owner     <= win;
                        rr_last   <= win;
                        ext_q     <= beat_ext;
                        acc       <= '0;
                        count     <= 4'd1;
                        state     <= LOOK;
                    end
                end
                LOOK: begin
                    acc <= acc_next;
                    if (ext_q && (count < MAX_CNT)) begin
                        state <= CHAIN;
`ifdef IMM_CHAIN_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        // Result is registered on the way into DONE so
                        // q_valid and q line up in the DONE cycle.
                        state     <= DONE;
                        q_r       <= acc_next;
                        q_id_r    <= owner;
                        q_ovf_r   <= ext_q;
                        q_valid_r <= 1'b1;
`ifdef IMM_CHAIN_TIMEOUT_EN
                        q_err_r   <= 1'b0;
`endif
                    end
                end
                CHAIN: begin
                    if (owner_req) begin
                        imm_sel_r <= beat_sel;
                        ext_q     <= beat_ext;
                        count     <= count + 4'd1;
                        state     <= LOOK;
                    end
`ifdef IMM_CHAIN_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LIMIT) begin
                        state     <= DONE;
                        q_r       <= acc;
                        q_id_r    <= owner;
                        q_ovf_r   <= 1'b0;
                        q_err_r   <= 1'b1;
                        q_valid_r <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_table_sequencer.sv
// tb_imm_table_sequencer
// Directed bench for imm_table_sequencer. Requester beats are queued per
// requester and presented with the req/gnt handshake. A transaction-level
// model predicts grants, result timing and values every cycle; a few
// literal expectations pin the model to hand-computed numbers.
module tb_imm_table_sequencer;

    localparam int MAX_BEATS = 4;
    localparam int TMO       = 15;

    typedef struct packed {
        logic [2:0] sel;
        logic       ext;
    } beat_t;

    typedef struct {
        logic [15:0] q;
        logic        id;
        logic        ovf;
        logic        err;
        int          cyc;
    } res_t;

    typedef struct {
        logic id;
        int   cyc;
    } glog_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_table_sequencer_if bus ();

    imm_table_sequencer #(
        .MAX_BEATS (MAX_BEATS),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [15:0] tbl [8] = '{16'h0000, 16'h0001, 16'h0020, 16'h0040,
                             16'h0060, 16'hFFFF, 16'h0090, 16'h0009};
    assign bus.imm_in = tbl[bus.imm_sel];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    beat_t q0[$];
    beat_t q1[$];
    res_t  obs[$];
    glog_t glog[$];
    logic  seen_g0 = 1'b0;
    logic  seen_g1 = 1'b0;

    task automatic push(input int who, input int sel, input bit ext);
        beat_t b;
        b.sel = 3'(sel);
        b.ext = ext;
        if (who == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    // Requester drivers: pop a beat once it has been granted, present the
    // next one; select/extend are garbage while no request is pending.
    initial begin
        bus.req0 = 1'b0; bus.sel0 = 3'd0; bus.ext0 = 1'b0;
        bus.req1 = 1'b0; bus.sel1 = 3'd0; bus.ext1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (seen_g0 && q0.size() > 0) void'(q0.pop_front());
            if (seen_g1 && q1.size() > 0) void'(q1.pop_front());
            bus.req0 = (q0.size() > 0);
            bus.req1 = (q1.size() > 0);
            if (q0.size() > 0) begin bus.sel0 = q0[0].sel; bus.ext0 = q0[0].ext; end
            else begin bus.sel0 = 3'($urandom_range(7, 0)); bus.ext0 = 1'($urandom_range(1, 0)); end
            if (q1.size() > 0) begin bus.sel1 = q1[0].sel; bus.ext1 = q1[0].ext; end
            else begin bus.sel1 = 3'($urandom_range(7, 0)); bus.ext1 = 1'($urandom_range(1, 0)); end
        end
    end

    // Transaction-level model state.
    int          cyc = 0;
    bit          m_open;
    bit          m_owner;
    bit          m_rr;
    logic [15:0] m_sum;
    int          m_cnt;
    int          m_next_ok;
    int          m_free;
    int          m_res_cycle;
    logic [15:0] r_q;
    bit          r_id, r_ovf, r_err;
    logic [15:0] h_q;
    bit          h_id, h_ovf, h_err;
    logic [2:0]  m_sel;

    task automatic model_reset();
        m_open = 0; m_owner = 0; m_rr = 1; m_sum = '0; m_cnt = 0;
        m_next_ok = 0; m_free = 0; m_res_cycle = -1;
        r_q = '0; r_id = 0; r_ovf = 0; r_err = 0;
        h_q = '0; h_id = 0; h_ovf = 0; h_err = 0;
        m_sel = '0;
    endtask

    initial model_reset();

    logic       e_g0, e_g1, e_v;
    bit         gw, gext;
    logic [2:0] gsel;

    always @(negedge clk) begin
        cyc++;
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        e_v  = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            e_v = (m_res_cycle == cyc);
            if (e_v) begin
                h_q = r_q; h_id = r_id; h_ovf = r_ovf; h_err = r_err;
                m_res_cycle = -1;
            end
            if (m_open) begin
                if (cyc >= m_next_ok) begin
                    if (m_owner ? bus.req1 : bus.req0) begin
                        if (m_owner) e_g1 = 1'b1; else e_g0 = 1'b1;
                    end
`ifdef IMM_CHAIN_TIMEOUT_EN
                    else if (cyc == m_next_ok + TMO) begin
                        m_res_cycle = cyc + 1;
                        r_q = m_sum; r_id = m_owner; r_ovf = 0; r_err = 1;
                        m_open = 0;
                        m_free = cyc + 2;
                    end
`endif
                end
            end else if (cyc >= m_free) begin
                if (bus.req0 && bus.req1) begin
                    if (m_rr) e_g0 = 1'b1; else e_g1 = 1'b1;
                end else if (bus.req0) e_g0 = 1'b1;
                else if (bus.req1) e_g1 = 1'b1;
            end
        end

        check("gnt0",    bus.gnt0,    e_g0);
        check("gnt1",    bus.gnt1,    e_g1);
        check("q_valid", bus.q_valid, e_v);
        check("q",       bus.q,       h_q);
        check("q_id",    bus.q_id,    h_id);
        check("q_ovf",   bus.q_ovf,   h_ovf);
        check("q_err",   bus.q_err,   h_err);
        check("imm_sel", bus.imm_sel, m_sel);

        if (rst_n && bus.q_valid === 1'b1)
            obs.push_back('{q: bus.q, id: bus.q_id, ovf: bus.q_ovf, err: bus.q_err, cyc: cyc});
        if (bus.gnt0 === 1'b1) glog.push_back('{id: 1'b0, cyc: cyc});
        if (bus.gnt1 === 1'b1) glog.push_back('{id: 1'b1, cyc: cyc});
        seen_g0 = (bus.gnt0 === 1'b1);
        seen_g1 = (bus.gnt1 === 1'b1);

        if (e_g0 || e_g1) begin
            gw   = e_g1;
            gsel = gw ? bus.sel1 : bus.sel0;
            gext = gw ? bus.ext1 : bus.ext0;
            m_sel = gsel;
            if (!m_open) begin
                m_open = 1; m_owner = gw; m_rr = gw; m_sum = '0; m_cnt = 0;
            end
            m_sum = m_sum + tbl[gsel];
            m_cnt++;
            if (gext && m_cnt < MAX_BEATS) begin
                m_next_ok = cyc + 2;
            end else begin
                m_res_cycle = cyc + 2;
                r_q = m_sum; r_id = m_owner;
                r_ovf = gext && (m_cnt == MAX_BEATS);
                r_err = 0;
                m_open = 0;
                m_free = cyc + 3;
            end
        end
    end

    task automatic idle_wait(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (q0.size() == 0 && q1.size() == 0 && !m_open && m_res_cycle < 0 &&
                !bus.req0 && !bus.req1) begin
                done = 1;
                break;
            end
        end
        check("idle_wait_budget", done, 1'b1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_res(input string nm, input int idx, input logic [15:0] q,
                              input bit id, input bit ovf, input bit err);
        if (idx < obs.size()) begin
            check({nm, "_q"},   obs[idx].q,   q);
            check({nm, "_id"},  obs[idx].id,  id);
            check({nm, "_ovf"}, obs[idx].ovf, ovf);
            check({nm, "_err"}, obs[idx].err, err);
        end else begin
            check({nm, "_present"}, obs.size(), idx + 1);
        end
    endtask

    int o0, gl;

    initial begin
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;

        // 1: plain lookup
        o0 = obs.size(); gl = glog.size();
        push(0, 3, 0);
        idle_wait(50);
        check("t1_nres", obs.size() - o0, 1);
        expect_res("t1", o0, 16'h0040, 0, 0, 0);
        if (obs.size() > o0 && glog.size() > gl)
            check("t1_latency", obs[o0].cyc - glog[gl].cyc, 2);

        // 2: chain on requester 1 with requester 0 held off
        o0 = obs.size(); gl = glog.size();
        push(1, 4, 1); push(1, 3, 1); push(1, 7, 0);
        push(0, 2, 0);
        idle_wait(80);
        check("t2_ngnt", glog.size() - gl, 4);
        expect_res("t2a", o0, 16'h00A9, 1, 0, 0);
        expect_res("t2b", o0 + 1, 16'h0020, 0, 0, 0);
        if (glog.size() >= gl + 4 && obs.size() > o0) begin
            check("t2_first_id", glog[gl].id, 1'b1);
            check("t2_g0_id", glog[gl + 3].id, 1'b0);
            check("t2_g0_after_done", glog[gl + 3].cyc - obs[o0].cyc, 1);
        end

        // 3: modulo-2^16 wrap
        o0 = obs.size();
        push(0, 1, 1); push(0, 5, 0);
        push(0, 0, 1); push(0, 5, 0);
        idle_wait(80);
        expect_res("t3a", o0, 16'h0000, 0, 0, 0);
        expect_res("t3b", o0 + 1, 16'hFFFF, 0, 0, 0);

        // 4: round-robin with both requesting straight out of reset
        #1 rst_n = 1'b0;
        o0 = obs.size(); gl = glog.size();
        push(0, 2, 0); push(0, 3, 0);
        push(1, 4, 0); push(1, 7, 0);
        cycles(2);
        check("t4_rst_q", bus.q, 16'h0000);
        check("t4_rst_gnt0", bus.gnt0, 1'b0);
        rst_n = 1'b1;
        idle_wait(80);
        check("t4_ngnt", glog.size() - gl, 4);
        if (glog.size() >= gl + 4) begin
            check("t4_g0", glog[gl].id, 1'b0);
            check("t4_g1", glog[gl + 1].id, 1'b1);
            check("t4_g2", glog[gl + 2].id, 1'b0);
            check("t4_g3", glog[gl + 3].id, 1'b1);
        end
        expect_res("t4a", o0,     16'h0020, 0, 0, 0);
        expect_res("t4b", o0 + 1, 16'h0060, 1, 0, 0);
        expect_res("t4c", o0 + 2, 16'h0040, 0, 0, 0);
        expect_res("t4d", o0 + 3, 16'h0009, 1, 0, 0);

        // 5: truncation at MAX_BEATS; fifth beat opens a new transaction
        o0 = obs.size();
        for (int i = 0; i < 5; i++) push(0, 1, 1);
        push(0, 0, 0);
        idle_wait(100);
        check("t5_nres", obs.size() - o0, 2);
        expect_res("t5a", o0, 16'h0004, 0, 1, 0);
        expect_res("t5b", o0 + 1, 16'h0001, 0, 0, 0);

        // 6: reset in the middle of a chain
        o0 = obs.size();
        push(1, 4, 1); push(1, 3, 1);
        cycles(10);
        push(0, 1, 0);
        cycles(3);
        check("t6_no_res_mid", obs.size() - o0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("t6_rst_gnt0", bus.gnt0, 1'b0);
        check("t6_rst_gnt1", bus.gnt1, 1'b0);
        check("t6_rst_sel", bus.imm_sel, 3'd0);
        check("t6_rst_q", bus.q, 16'h0000);
        check("t6_rst_qid", bus.q_id, 1'b0);
        check("t6_rst_valid", bus.q_valid, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        idle_wait(50);
        check("t6_nres", obs.size() - o0, 1);
        expect_res("t6", o0, 16'h0001, 0, 0, 0);

        // 7: owner stops mid-chain
        o0 = obs.size(); gl = glog.size();
        push(0, 6, 1);
`ifdef IMM_CHAIN_TIMEOUT_EN
        idle_wait(100);
        expect_res("t7_tmo", o0, 16'h0090, 0, 0, 1);
        if (obs.size() > o0 && glog.size() > gl)
            check("t7_tmo_cycle", obs[o0].cyc - glog[gl].cyc, 2 + TMO + 1);
        push(0, 3, 0);
        idle_wait(50);
        expect_res("t7_clear", o0 + 1, 16'h0040, 0, 0, 0);
`else
        cycles(40);
        check("t7_waiting", obs.size() - o0, 0);
        check("t7_err_tied", bus.q_err, 1'b0);
        push(0, 0, 0);
        idle_wait(50);
        expect_res("t7_close", o0, 16'h0090, 0, 0, 0);
`endif

        cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule
